tlb_param: RTL

- Parametrised, fully associative MIPS-style joint TLB.
- Next generation of the single-port combinational TLB:
  - configurable entry count and ASID width;
  - registered one-cycle lookup pipeline;
  - TLBP probe and TLBR read with registered results;
  - built-in Random index counter with Wired support.
- Sits between the MMU address stage and CP0. CP0 drives write, read and probe; the pipeline drives lookup.

---
 rtl/tlb_param_if.sv | 69 ++++++
 rtl/tlb_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tlb_param_if.sv
// Bundle of CP0 (write/read/probe) and MMU lookup signals between the core and tlb_param.
// TLB_DUAL_LOOKUP_EN adds the second, load-only lookup channel (if_*).
interface tlb_param_if #(
  parameter int IDX_W  = 5,
  parameter int ASID_W = 8
);
  logic [ASID_W-1:0] cur_asid;
  logic [IDX_W-1:0]  wired;
  logic              wen;
  logic              wr_random;
  logic [IDX_W-1:0]  w_idx;
  logic [11:0]       w_mask;
  logic [31:0]       w_entryhi;
  logic [31:0]       w_entrylo0;
  logic [31:0]       w_entrylo1;
  logic              rd_req;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic [11:0]       rd_mask;
  logic [31:0]       rd_entryhi;
  logic [31:0]       rd_entrylo0;
  logic [31:0]       rd_entrylo1;
  logic              pr_req;
  logic [18:0]       probe_vpn2;
  logic              pr_done;
  logic              pr_miss;
  logic [IDX_W-1:0]  pr_idx;
  logic [IDX_W-1:0]  random_idx;
  logic              lk_req;
  logic [31:0]       lk_vaddr;
  logic              lk_store;
  logic              lk_valid;
  logic [31:0]       lk_paddr;
  logic [2:0]        lk_cache;
  logic              lk_miss;
  logic              lk_invalid;
  logic              lk_modify;
`ifdef TLB_DUAL_LOOKUP_EN
  logic              if_req;
  logic [31:0]       if_vaddr;
  logic              if_valid;
  logic [31:0]       if_paddr;
  logic [2:0]        if_cache;
  logic              if_miss;
  logic              if_invalid;
`endif

  modport master (
    output cur_asid, wired, wen, wr_random, w_idx, w_mask, w_entryhi, w_entrylo0, w_entrylo1,
           rd_req, rd_idx, pr_req, probe_vpn2, lk_req, lk_vaddr, lk_store,
`ifdef TLB_DUAL_LOOKUP_EN
           if_req, if_vaddr,
    input  if_valid, if_paddr, if_cache, if_miss, if_invalid,
`endif
    input  rd_valid, rd_mask, rd_entryhi, rd_entrylo0, rd_entrylo1, pr_done, pr_miss, pr_idx,
           random_idx, lk_valid, lk_paddr, lk_cache, lk_miss, lk_invalid, lk_modify
  );

  modport slave (
    input  cur_asid, wired, wen, wr_random, w_idx, w_mask, w_entryhi, w_entrylo0, w_entrylo1,
           rd_req, rd_idx, pr_req, probe_vpn2, lk_req, lk_vaddr, lk_store,
`ifdef TLB_DUAL_LOOKUP_EN
           if_req, if_vaddr,
    output if_valid, if_paddr, if_cache, if_miss, if_invalid,
`endif
    output rd_valid, rd_mask, rd_entryhi, rd_entrylo0, rd_entrylo1, pr_done, pr_miss, pr_idx,
           random_idx, lk_valid, lk_paddr, lk_cache, lk_miss, lk_invalid, lk_modify
  );
endinterface

// File: rtl/tlb_param.sv
// Fully associative MIPS-style joint TLB with registered lookup, TLBP/TLBR and Random/Wired.
// TLB_DUAL_LOOKUP_EN adds an independent load-only lookup channel (if_*).
module tlb_param #(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int ASID_W      = 8
) (
  input logic        clk,
  input logic        resetn,
  tlb_param_if.slave bus
);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef struct packed {
    logic [18:0]       vpn2;
    logic [ASID_W-1:0] asid;
    logic [11:0]       mask;
    logic              g;
    logic [19:0]       pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [19:0]       pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } entry_t;

  typedef struct packed {
    logic        miss;
    logic        invalid;
    logic        modify;
    logic [31:0] paddr;
    logic [2:0]  cache;
  } lk_res_t;

  entry_t           tlb_q [NUM_ENTRIES];
  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] random_nxt;
  logic [IDX_W-1:0] wr_tgt;
  entry_t           new_e;
  lk_res_t          lk_res;
  logic [IDX_W:0]   pr_m;
  entry_t           rd_e;
  logic             unused_bits;

  // Returns {hit, idx}; scanning downward leaves the lowest matching index.
  function automatic logic [IDX_W:0] find_match(input logic [18:0] vpn2, input logic [ASID_W-1:0] asid);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if ((((tlb_q[i].vpn2 ^ vpn2) & ~{7'b0, tlb_q[i].mask}) == 19'b0) &&
          (tlb_q[i].g || (tlb_q[i].asid == asid)))
        r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  function automatic lk_res_t translate(input logic [31:0] va, input logic store,
                                        input logic [ASID_W-1:0] asid);
    lk_res_t        r;
    logic [IDX_W:0] m;
    entry_t         e;
    logic [12:0]    sel;
    logic           odd;
    logic [19:0]    pfn;
    logic [2:0]     c;
    logic           d;
    logic           v;
    r   = '0;
    m   = find_match(va[31:13], asid);
    e   = tlb_q[m[IDX_W-1:0]];
    // One-hot at bit n (trailing ones of mask) picks va[12+n] as the odd/even select.
    sel = {e.mask, 1'b1} & ~({e.mask, 1'b1} >> 1);
    odd = |(va[24:12] & sel);
    pfn = odd ? e.pfn1 : e.pfn0;
    c   = odd ? e.c1 : e.c0;
    d   = odd ? e.d1 : e.d0;
    v   = odd ? e.v1 : e.v0;
    if (!m[IDX_W]) begin
      r.miss = 1'b1;
    end else begin
      r.paddr   = {(pfn & ~{8'b0, e.mask}) | (va[31:12] & {8'b0, e.mask}), va[11:0]};
      r.cache   = c;
      r.invalid = !v;
      r.modify  = v && store && !d;
    end
    return r;
  endfunction

  always_comb begin
    new_e      = '0;
    new_e.vpn2 = bus.w_entryhi[31:13];
    new_e.asid = bus.w_entryhi[ASID_W-1:0];
    new_e.mask = bus.w_mask;
    new_e.g    = bus.w_entrylo0[0] & bus.w_entrylo1[0];
    new_e.pfn0 = bus.w_entrylo0[25:6];
    new_e.c0   = bus.w_entrylo0[5:3];
    new_e.d0   = bus.w_entrylo0[2];
    new_e.v0   = bus.w_entrylo0[1];
    new_e.pfn1 = bus.w_entrylo1[25:6];
    new_e.c1   = bus.w_entrylo1[5:3];
    new_e.d1   = bus.w_entrylo1[2];
    new_e.v1   = bus.w_entrylo1[1];
    wr_tgt     = bus.wr_random ? random_q : bus.w_idx;
    lk_res     = translate(bus.lk_vaddr, bus.lk_store, bus.cur_asid);
    pr_m       = find_match(bus.probe_vpn2, bus.cur_asid);
    rd_e       = tlb_q[bus.rd_idx];
    random_nxt = random_q - IDX_W'(1);
    if ((bus.wen && bus.wr_random) || (bus.wired >= MAX_IDX) ||
        (random_q == bus.wired) || (random_q == '0))
      random_nxt = MAX_IDX;
  end

  assign unused_bits    = ^{bus.w_entryhi[12:ASID_W], bus.w_entrylo0[31:26], bus.w_entrylo1[31:26]};
  assign bus.random_idx = random_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tlb_q[i] <= '0;
      random_q        <= MAX_IDX;
      bus.rd_valid    <= 1'b0;
      bus.rd_mask     <= '0;
      bus.rd_entryhi  <= '0;
      bus.rd_entrylo0 <= '0;
      bus.rd_entrylo1 <= '0;
      bus.pr_done     <= 1'b0;
      bus.pr_miss     <= 1'b0;
      bus.pr_idx      <= '0;
      bus.lk_valid    <= 1'b0;
      bus.lk_paddr    <= '0;
      bus.lk_cache    <= '0;
      bus.lk_miss     <= 1'b0;
      bus.lk_invalid  <= 1'b0;
      bus.lk_modify   <= 1'b0;
    end else begin
      if (bus.wen) tlb_q[wr_tgt] <= new_e;
      random_q     <= random_nxt;
      bus.rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        bus.rd_mask     <= rd_e.mask;
        bus.rd_entryhi  <= {rd_e.vpn2, 13'(rd_e.asid)};
        bus.rd_entrylo0 <= {6'b0, rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g};
        bus.rd_entrylo1 <= {6'b0, rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g};
      end
      bus.pr_done <= bus.pr_req;
      if (bus.pr_req) begin
        bus.pr_miss <= !pr_m[IDX_W];
        bus.pr_idx  <= pr_m[IDX_W] ? pr_m[IDX_W-1:0] : '0;
      end
      bus.lk_valid <= bus.lk_req;
      if (bus.lk_req) begin
        bus.lk_paddr   <= lk_res.paddr;
        bus.lk_cache   <= lk_res.cache;
        bus.lk_miss    <= lk_res.miss;
        bus.lk_invalid <= lk_res.invalid;
        bus.lk_modify  <= lk_res.modify;
      end
    end
  end

`ifdef TLB_DUAL_LOOKUP_EN
  lk_res_t if_res;

  always_comb if_res = translate(bus.if_vaddr, 1'b0, bus.cur_asid);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.if_valid   <= 1'b0;
      bus.if_paddr   <= '0;
      bus.if_cache   <= '0;
      bus.if_miss    <= 1'b0;
      bus.if_invalid <= 1'b0;
    end else begin
      bus.if_valid <= bus.if_req;
      if (bus.if_req) begin
        bus.if_paddr   <= if_res.paddr;
        bus.if_cache   <= if_res.cache;
        bus.if_miss    <= if_res.miss;
        bus.if_invalid <= if_res.invalid;
      end
    end
  end
`endif
endmodule
